// File: rtl/vga_sync_gen.sv
// Raster timing generator. It divides the system clock down to a pixel tick, steps
// the horizontal and vertical counters, and drives active-low hsync/vsync plus a
// visible-area flag. The default timing is 640x480@60 from a 50 MHz clock.
// Every output is a flop. hsync, vsync and video_on are decoded from the next-state
// counter values, so they change in the same clock as addrH/addrV.

module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] addrH,
    output logic [9:0] addrV,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    // A divider of width 1 is still kept when CLK_DIV is 1, so the logic below has
    // only one shape. In that case it sits at 0, which is also the last phase.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_LO    = 10'(HS_START);
    localparam logic [9:0]    HS_HI    = 10'(HS_END);
    localparam logic [9:0]    VS_LO    = 10'(VS_START);
    localparam logic [9:0]    VS_HI    = 10'(VS_END);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          adv;
    logic          h_end;
    logic          v_end;
    logic [9:0]    h_d;
    logic [9:0]    v_d;
    logic          hs_d;
    logic          vs_d;
    logic          vo_d;

    // Next divider phase and next counter values. Enable gates everything.
    // The ">=" compares make any out-of-range state fall back into the legal range.
    always_comb begin
        adv   = en && (div_q >= DIV_LAST);
        h_end = (addrH >= H_LAST);
        v_end = (addrV >= V_LAST);
        div_d = div_q;
        h_d   = addrH;
        v_d   = addrV;
        if (en) begin
            div_d = adv ? '0 : div_q + DW'(1);
        end
        if (adv) begin
            if (h_end) begin
                h_d = '0;
                v_d = v_end ? '0 : addrV + 10'd1;
            end else begin
                h_d = addrH + 10'd1;
            end
        end
    end

    // Decode sync and visible area from the next counter values, not the current ones.
    always_comb begin
        hs_d = !((h_d >= HS_LO) && (h_d < HS_HI));
        vs_d = !((v_d >= VS_LO) && (v_d < VS_HI));
        vo_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    // Raster state and registered outputs. While en is low all of it holds, and the
    // two strobes are forced low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            addrH       <= '0;
            addrV       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            div_q       <= div_d;
            addrH       <= h_d;
            addrV       <= v_d;
            hsync       <= hs_d;
            vsync       <= vs_d;
            video_on    <= vo_d;
            // The tick is high for the whole cycle in which the divider sits on its
            // last phase. The counter advance happens at the end of that cycle.
            pixel_tick  <= (div_d == DIV_LAST);
            frame_start <= adv && h_end && v_end;
        end else begin
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. It builds three instances:
//   0: default 640x480 timing, CLK_DIV=2
//   1: reduced 25x17 raster,   CLK_DIV=3
//   2: reduced 25x17 raster,   CLK_DIV=1
// The reduced rasters let whole frames run in a short time. The reference model
// treats the raster as a linear pixel index modulo the frame size, plus a divider
// phase. Expected outputs are queued when stimulus is applied, and a monitor pops
// and compares them on the falling edge.

module tb_vga_sync_gen;

    localparam int N = 3;
    localparam int P_CD[N] = '{2, 3, 1};
    localparam int P_HD[N] = '{640, 16, 16};
    localparam int P_HF[N] = '{16, 2, 2};
    localparam int P_HS[N] = '{96, 4, 4};
    localparam int P_HB[N] = '{48, 3, 3};
    localparam int P_VD[N] = '{480, 10, 10};
    localparam int P_VF[N] = '{10, 2, 2};
    localparam int P_VS[N] = '{2, 2, 2};
    localparam int P_VB[N] = '{33, 3, 3};

    typedef struct {
        int         d;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
        logic       fs;
    } exp_t;

    logic         clk;
    logic [N-1:0] rst_n;
    logic [N-1:0] en;
    logic [9:0]   ah [N];
    logic [9:0]   av [N];
    logic [N-1:0] hs_o, vs_o, vo, pt, fs_o;

    int   nchk;
    int   nfail;
    exp_t sbq[$];

    // Reference model state: divider phase, linear pixel index, and the two strobes.
    int ph  [N];
    int pix [N];
    bit tk  [N];
    bit fsm [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_sync_gen #(
            .CLK_DIV(P_CD[g]), .H_DISPLAY(P_HD[g]), .H_FRONT(P_HF[g]),
            .H_SYNC(P_HS[g]), .H_BACK(P_HB[g]), .V_DISPLAY(P_VD[g]),
            .V_FRONT(P_VF[g]), .V_SYNC(P_VS[g]), .V_BACK(P_VB[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .en(en[g]),
            .addrH(ah[g]), .addrV(av[g]), .hsync(hs_o[g]), .vsync(vs_o[g]),
            .video_on(vo[g]), .pixel_tick(pt[g]), .frame_start(fs_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int htot(int d);
        return P_HD[d] + P_HF[d] + P_HS[d] + P_HB[d];
    endfunction

    function automatic int frame(int d);
        return htot(d) * (P_VD[d] + P_VF[d] + P_VS[d] + P_VB[d]);
    endfunction

    function automatic int model_h(int d);
        return pix[d] % htot(d);
    endfunction

    function automatic int model_v(int d);
        return pix[d] / htot(d);
    endfunction

    function automatic exp_t model_out(int d);
        exp_t e;
        int h = model_h(d);
        int v = model_v(d);
        e.d  = d;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = !(h >= P_HD[d] + P_HF[d] && h < P_HD[d] + P_HF[d] + P_HS[d]);
        e.vs = !(v >= P_VD[d] + P_VF[d] && v < P_VD[d] + P_VF[d] + P_VS[d]);
        e.vo = (h < P_HD[d]) && (v < P_VD[d]);
        e.pt = tk[d];
        e.fs = fsm[d];
        return e;
    endfunction

    function automatic void model_reset(int d);
        ph[d] = 0; pix[d] = 0; tk[d] = 0; fsm[d] = 0;
    endfunction

    function automatic void model_step(int d, bit e);
        if (e) begin
            if (ph[d] == P_CD[d] - 1) begin
                ph[d]  = 0;
                pix[d] = (pix[d] + 1) % frame(d);
                fsm[d] = (pix[d] == 0);
            end else begin
                ph[d]  = ph[d] + 1;
                fsm[d] = 0;
            end
            tk[d] = (ph[d] == P_CD[d] - 1);
        end else begin
            tk[d]  = 0;
            fsm[d] = 0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // The scoreboard monitor. All queued entries belong to the edge just before
    // this falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("d%0d addrH", e.d), 32'(ah[e.d]), 32'(e.h));
                chk($sformatf("d%0d addrV", e.d), 32'(av[e.d]), 32'(e.v));
                chk($sformatf("d%0d hsync", e.d), 32'(hs_o[e.d]), 32'(e.hs));
                chk($sformatf("d%0d vsync", e.d), 32'(vs_o[e.d]), 32'(e.vs));
                chk($sformatf("d%0d video_on", e.d), 32'(vo[e.d]), 32'(e.vo));
                chk($sformatf("d%0d pixel_tick", e.d), 32'(pt[e.d]), 32'(e.pt));
                chk($sformatf("d%0d frame_start", e.d), 32'(fs_o[e.d]), 32'(e.fs));
            end
        end
    end

    // Apply enables, let one rising edge pass, queue the model's prediction,
    // then return at the following falling edge.
    task automatic cycle(input logic [N-1:0] env);
        en = env;
        @(posedge clk);
        for (int d = 0; d < N; d++) begin
            model_step(d, env[d]);
            sbq.push_back(model_out(d));
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("d%0d reset addrH", d), 32'(ah[d]), 0);
        chk($sformatf("d%0d reset addrV", d), 32'(av[d]), 0);
        chk($sformatf("d%0d reset hsync", d), 32'(hs_o[d]), 1);
        chk($sformatf("d%0d reset vsync", d), 32'(vs_o[d]), 1);
        chk($sformatf("d%0d reset video_on", d), 32'(vo[d]), 1);
        chk($sformatf("d%0d reset pixel_tick", d), 32'(pt[d]), 0);
        chk($sformatf("d%0d reset frame_start", d), 32'(fs_o[d]), 0);
    endtask

    // This task is called just after a falling edge. Reset is asserted and released
    // between clock edges, so the output check shows the asynchronous path.
    task automatic pulse_reset(input int d);
        #1 rst_n[d] = 1'b0;
        #1 chk_reset(d);
        #1 rst_n[d] = 1'b1;
        model_reset(d);
    endtask

    initial begin
        int hs_low, ticks, vo_low, first_hs, vblank_vo, n, frozen_ticks;
        int last_fs [N];
        logic [N-1:0] env;

        nchk  = 0;
        nfail = 0;
        rst_n = '0;
        en    = '0;
        @(negedge clk);
        #2;
        for (int d = 0; d < N; d++) begin
            chk_reset(d);
            model_reset(d);
        end
        rst_n = '1;

        // Free-running: line timing of the full-size raster, and frame periods of
        // the reduced rasters.
        hs_low = 0; ticks = 0; vo_low = 0; first_hs = -1; vblank_vo = 0;
        for (int d = 0; d < N; d++) last_fs[d] = 0;
        for (int i = 1; i <= 3300; i++) begin
            cycle('1);
            if (i <= 1600) begin
                if (!hs_o[0]) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = int'(ah[0]);
                end
                if (pt[0]) ticks++;
                if (!vo[0]) vo_low++;
            end
            if (i == 1600) begin
                chk("d0 addrH after 1600 clks", 32'(ah[0]), 0);
                chk("d0 addrV after 1600 clks", 32'(av[0]), 1);
            end
            for (int d = 0; d < N; d++) begin
                if (fs_o[d]) begin
                    chk($sformatf("d%0d frame period", d), i - last_fs[d], P_CD[d] * frame(d));
                    last_fs[d] = i;
                end
            end
            if (vo[1] && av[1] >= 10'(P_VD[1])) vblank_vo++;
        end
        chk("d0 hsync low clks per line", hs_low, 192);
        chk("d0 hsync low start addrH", first_hs, 656);
        chk("d0 pixel_tick per line", ticks, 800);
        chk("d0 video_on low clks per line", vo_low, 320);
        chk("d1 video_on in vblank", vblank_vo, 0);
        chk("d1 frames seen", last_fs[1], 2 * 1275);
        chk("d2 frames seen", last_fs[2], 7 * 425);

        // Freeze the full-size instance for 37 clocks at addrH=300.
        n = 0;
        while (!(model_h(0) == 300 && ph[0] == 0) && n < 4000) begin
            cycle('1);
            n++;
        end
        chk("d0 reached addrH 300", 32'(ah[0]), 300);
        frozen_ticks = 0;
        repeat (37) begin
            cycle(3'b110);
            if (pt[0]) frozen_ticks++;
        end
        chk("d0 ticks while disabled", frozen_ticks, 0);
        chk("d0 addrH held while disabled", 32'(ah[0]), 300);
        chk("d0 hsync held while disabled", 32'(hs_o[0]), 1);
        n = 0;
        while (ah[0] != 10'd301 && n < 10) begin
            cycle('1);
            n++;
        end
        chk("d0 clks to addrH 301 after resume", n, 2);

        // Reset pulse inside hsync on the full-size raster.
        n = 0;
        while (model_h(0) != 700 && n < 4000) begin
            cycle('1);
            n++;
        end
        chk("d0 hsync low before reset", 32'(hs_o[0]), 0);
        pulse_reset(0);
        cycle('1);
        chk("d0 addrH 1 clk after release", 32'(ah[0]), 0);
        cycle('1);
        chk("d0 addrH 2 clks after release", 32'(ah[0]), 1);

        // Reset pulse inside both hsync and vsync on a reduced raster.
        n = 0;
        while (!(model_v(1) == 13 && model_h(1) == 19) && n < 4000) begin
            cycle('1);
            n++;
        end
        chk("d1 vsync low before reset", 32'(vs_o[1]), 0);
        chk("d1 hsync low before reset", 32'(hs_o[1]), 0);
        pulse_reset(1);

        // Random enables with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            for (int d = 0; d < N; d++) env[d] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) pulse_reset(int'($urandom_range(0, N - 1)));
            cycle(env);
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
